// File: rtl/ccff_loader.sv
// Purpose: load a serial configuration chain from a word stream, then recirculate it once to check readback parity.
// Latency: a word accepted in cycle t shifts MSB-first from t+1; CHECK takes CHAIN_LEN cycles, then done.
// Backpressure: s_ready is high only in LOAD while the 1-word buffer is empty and chain bits remain to be fetched.
module ccff_loader #(
    parameter int CHAIN_LEN = 8,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              prog_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              shift_en,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BCNT_W = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(CHAIN_LEN);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   buf_dat;   // MSB is the next bit to shift
    logic [BCNT_W-1:0]   buf_cnt;   // valid bits left in the buffer
    logic [CNT_W-1:0]    rem_cnt;   // chain bits not yet fetched into the buffer
    logic [CNT_W-1:0]    bit_cnt;   // bits shifted in the current phase
    logic                p_load;
    logic                p_rb;
    logic                err_q;

    logic                accept;
    logic                load_shift;
    logic                go_load;
    logic [CNT_W-1:0]    take;

    // Handshake, shift qualification and how many bits of the next word are kept
    always_comb begin
        accept     = s_ready & s_valid;
        load_shift = (state == LOAD) && (buf_cnt != '0);
        go_load    = start && !abort && ((state == IDLE) || (state == DONE));
        // A final partial word only contributes its top rem_cnt bits
        if (32'(rem_cnt) >= WORD_W) begin
            take = CNT_W'(WORD_W);
        end else begin
            take = rem_cnt;
        end
    end

    assign s_ready   = (state == LOAD) && (buf_cnt == '0) && (rem_cnt != '0);
    assign shift_en  = load_shift || (state == CHECK);
    assign ccff_head = load_shift ? buf_dat[WORD_W-1] :
                       (state == CHECK) ? ccff_tail : 1'b0;
    assign busy      = (state == LOAD) || (state == CHECK);
    assign done      = (state == DONE);
    assign err       = err_q;

    // Control FSM with buffer, counters and parity accumulators
    always_ff @(posedge prog_clk) begin
        if (prog_reset || abort || go_load) begin
            // Reset, abort and a fresh start all begin from a clean slate
            state   <= (go_load && !prog_reset) ? LOAD : IDLE;
            rem_cnt <= (go_load && !prog_reset) ? FULL_LEN : '0;
            buf_dat <= '0;
            buf_cnt <= '0;
            bit_cnt <= '0;
            p_load  <= 1'b0;
            p_rb    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    // accept and load_shift never coincide: s_ready needs an empty buffer
                    if (accept) begin
                        buf_dat <= s_data;
                        buf_cnt <= BCNT_W'(take);
                        rem_cnt <= rem_cnt - take;
                    end else if (load_shift) begin
                        buf_dat <= buf_dat << 1;
                        buf_cnt <= buf_cnt - 1'b1;
                        p_load  <= p_load ^ buf_dat[WORD_W-1];
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            state   <= CHECK;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    // Tail is fed back to the head so the chain ends up unchanged
                    p_rb <= p_rb ^ ccff_tail;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt <= '0;
                        err_q   <= p_load ^ p_rb ^ ccff_tail;
                        state   <= DONE;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE hold until start, abort or reset
                    state <= state;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
// Bench for ccff_loader: an 8-bit and a 12-bit chain instance share stimulus, one is selected at a time.
// Expected head bits are queued at each accepted word and popped on each LOAD shift.
// Each scenario task checks its own outcomes; one summary line at the end.
module tb_ccff_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic        s_valid;
    logic [7:0]  s_data;
    logic        stuck;
    bit          sel;          // 0: 8-bit chain instance, 1: 12-bit chain instance

    logic        start8, start12, vld8, vld12;
    logic        rdy8, head8, sh8, busy8, done8, err8, tail8;
    logic        rdy12, head12, sh12, busy12, done12, err12, tail12;
    logic [7:0]  chain8  = '0;
    logic [11:0] chain12 = '0;

    logic        o_ready, o_head, o_shift, o_busy, o_done, o_err;

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          exp_q[$];

    always #5 clk = ~clk;

    assign start8  = start & ~sel;
    assign start12 = start & sel;
    assign vld8    = s_valid & ~sel;
    assign vld12   = s_valid & sel;
    assign tail8   = stuck ? 1'b0 : chain8[7];
    assign tail12  = stuck ? 1'b0 : chain12[11];

    assign o_ready = sel ? rdy12  : rdy8;
    assign o_head  = sel ? head12 : head8;
    assign o_shift = sel ? sh12   : sh8;
    assign o_busy  = sel ? busy12 : busy8;
    assign o_done  = sel ? done12 : done8;
    assign o_err   = sel ? err12  : err8;

    // Shift-register models of the two configuration chains
    always @(posedge clk) begin
        if (sh8 === 1'b1)  chain8  <= {chain8[6:0], head8};
        if (sh12 === 1'b1) chain12 <= {chain12[10:0], head12};
    end

    ccff_loader #(.CHAIN_LEN(8), .WORD_W(8)) u_dut8 (
        .prog_clk(clk), .prog_reset(rst), .start(start8), .abort(abort),
        .s_data(s_data), .s_valid(vld8), .s_ready(rdy8), .ccff_head(head8),
        .ccff_tail(tail8), .shift_en(sh8), .busy(busy8), .done(done8), .err(err8)
    );

    ccff_loader #(.CHAIN_LEN(12), .WORD_W(8)) u_dut12 (
        .prog_clk(clk), .prog_reset(rst), .start(start12), .abort(abort),
        .s_data(s_data), .s_valid(vld12), .s_ready(rdy12), .ccff_head(head12),
        .ccff_tail(tail12), .shift_en(sh12), .busy(busy12), .done(done12), .err(err12)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = '0; stuck = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_checks++;
        if ({rdy8, head8, sh8, busy8, done8, err8} !== 6'b0) begin
            $display("FAIL reset_dut8: got %b want 000000", {rdy8, head8, sh8, busy8, done8, err8});
        end else n_pass++;
        n_checks++;
        if ({rdy12, head12, sh12, busy12, done12, err12} !== 6'b0) begin
            $display("FAIL reset_dut12: got %b want 000000", {rdy12, head12, sh12, busy12, done12, err12});
        end else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Full load plus check on the selected instance; poke>0 pulses start at that cycle
    task automatic run_load(input string nm, input logic [7:0] w0, input logic [7:0] w1,
                            input int nw, input int gap, input int poke, input int exp_done,
                            input bit exp_err, input bit chk_chain, input logic [11:0] exp_chain);
        int         len = sel ? 12 : 8;
        int         pushed = 0, wi = 0, gcnt = 0, lsh = 0, csh = 0;
        int         got_done = -1, idle_bad = 0, ready_bad = 0;
        logic [7:0] w;
        bit         acc, eb;
        exp_q.delete();
        start = 1'b1; s_valid = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 300 && got_done < 0; cyc++) begin
            start   = (cyc == poke);
            w       = (wi == 0) ? w0 : w1;
            s_valid = (wi < nw) && (gcnt == 0);
            s_data  = w;
            @(negedge clk);
            if (cyc == 1) begin
                n_checks++;
                if ({o_busy, o_done, o_err} !== 3'b100) begin
                    $display("FAIL %s first_cycle busy/done/err: got %b want 100", nm, {o_busy, o_done, o_err});
                end else n_pass++;
            end
            if (pushed >= len && o_ready === 1'b1) ready_bad++;
            acc = s_valid && (o_ready === 1'b1);
            if (o_done === 1'b1) begin
                got_done = cyc;
            end else if (o_shift === 1'b1) begin
                if (lsh < len) begin
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL %s head_bit[%0d]: got %b want none (queue empty)", nm, lsh, o_head);
                    end else begin
                        eb = exp_q.pop_front();
                        if (o_head !== eb) begin
                            $display("FAIL %s head_bit[%0d]: got %b want %b", nm, lsh, o_head, eb);
                        end else n_pass++;
                    end
                    lsh++;
                end else begin
                    csh++;
                end
            end else if (o_busy === 1'b1 && o_head !== 1'b0) begin
                idle_bad++;
            end
            if (acc) begin
                for (int b = 7; b >= 0 && pushed < len; b--) begin
                    exp_q.push_back(w[b]);
                    pushed++;
                end
                wi++;
                gcnt = (gap > 0) ? gap + 8 : 0;
            end else if (gcnt > 0) begin
                gcnt--;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; s_valid = 1'b0;
        n_checks++;
        if (got_done != exp_done) $display("FAIL %s done_cycle: got %0d want %0d", nm, got_done, exp_done);
        else n_pass++;
        n_checks++;
        if (lsh != len) $display("FAIL %s load_shifts: got %0d want %0d", nm, lsh, len);
        else n_pass++;
        n_checks++;
        if (csh != len) $display("FAIL %s check_shifts: got %0d want %0d", nm, csh, len);
        else n_pass++;
        n_checks++;
        if (o_err !== exp_err) $display("FAIL %s err: got %b want %b", nm, o_err, exp_err);
        else n_pass++;
        n_checks++;
        if (exp_q.size() != 0) $display("FAIL %s leftover_bits: got %0d want 0", nm, exp_q.size());
        else n_pass++;
        n_checks++;
        if (idle_bad != 0) $display("FAIL %s head_while_idle: got %0d cycles want 0", nm, idle_bad);
        else n_pass++;
        n_checks++;
        if (ready_bad != 0) $display("FAIL %s ready_after_last: got %0d cycles want 0", nm, ready_bad);
        else n_pass++;
        if (chk_chain) begin
            n_checks++;
            if ((sel ? chain12 : {4'b0, chain8}) !== exp_chain) begin
                $display("FAIL %s chain: got %h want %h", nm, (sel ? chain12 : {4'b0, chain8}), exp_chain);
            end else n_pass++;
        end
    endtask

    task automatic check_all_zero(input string nm);
        @(negedge clk);
        n_checks++;
        if ({o_ready, o_head, o_shift, o_busy, o_done, o_err} !== 6'b0) begin
            $display("FAIL %s outputs: got %b want 000000", nm, {o_ready, o_head, o_shift, o_busy, o_done, o_err});
        end else n_pass++;
        @(posedge clk);
        #1;
    endtask

    // Start a load and run until total shift_en cycles reach target
    task automatic shift_until(input string nm, input int target);
        int sh = 0;
        start = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0; s_valid = 1'b1; s_data = 8'hC3;
        for (int cyc = 0; cyc < 40 && sh < target; cyc++) begin
            @(negedge clk);
            if (o_shift === 1'b1) sh++;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        n_checks++;
        if (sh != target) $display("FAIL %s reach_shift: got %0d want %0d", nm, sh, target);
        else n_pass++;
    endtask

    task automatic test_abort();
        sel = 1'b0;
        shift_until("abort_load", 3);
        abort = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        abort = 1'b0;
        check_all_zero("abort_in_load");
        run_load("after_abort", 8'h5A, 8'h00, 1, 0, 0, 18, 1'b0, 1'b1, 12'h05A);
    endtask

    task automatic test_reset_in_check();
        sel = 1'b0;
        shift_until("reset_check", 11);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_all_zero("reset_in_check");
    endtask

    task automatic test_start_abort_done();
        sel = 1'b0;
        run_load("pre_abort_done", 8'h81, 8'h00, 1, 0, 0, 18, 1'b0, 1'b1, 12'h081);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        start = 1'b0; abort = 1'b0;
        check_all_zero("start_abort_in_done");
        check_all_zero("idle_hold");
        run_load("from_idle", 8'h3C, 8'h00, 1, 0, 0, 18, 1'b0, 1'b1, 12'h03C);
    endtask

    initial begin
        test_reset();
        sel = 1'b0;
        run_load("scen1_a5", 8'hA5, 8'h00, 1, 0, 0, 18, 1'b0, 1'b1, 12'h0A5);
        stuck = 1'b1;
        run_load("scen2_stuck", 8'hA4, 8'h00, 1, 0, 0, 18, 1'b1, 1'b0, 12'h000);
        stuck = 1'b0;
        sel = 1'b1;
        run_load("scen3_partial", 8'hFF, 8'hF0, 2, 0, 5, 27, 1'b0, 1'b1, 12'hFFF);
        run_load("scen4_nogap", 8'hA5, 8'h3C, 2, 0, 0, 27, 1'b0, 1'b1, 12'hA53);
        run_load("scen4_gap", 8'hA5, 8'h3C, 2, 5, 0, 32, 1'b0, 1'b1, 12'hA53);
        test_abort();
        test_reset_in_check();
        test_start_abort_done();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ccff_loader.md
CCFF_LOADER -- requirements
Module: ccff_loader

Interface
REQ-001 The block SHALL expose parameter CHAIN_LEN, default 8, giving the total configuration-chain length in bits (must be >= 1).
REQ-002 The block SHALL expose parameter WORD_W, default 8, giving the bitstream word width in bits (must be >= 1).
REQ-003 The block SHALL have one clock, prog_clk, with a synchronous, active-high reset, prog_reset.
REQ-004 Port: prog_clk  input  1  configuration clock; all state updates on its rising edge.
REQ-005 Port: prog_reset  input  1  synchronous active-high reset.
REQ-006 Port: start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
REQ-007 Port: abort  input  1  cancels any operation and returns to IDLE.
REQ-008 Port: s_data  input  WORD_W  bitstream word, MSB shifted first.
REQ-009 Port: s_valid  input  1  s_data valid.
REQ-010 Port: s_ready  output  1  loader accepts s_data this cycle.
REQ-011 Port: ccff_head  output  1  serial bit driven into the chain head.
REQ-012 Port: ccff_tail  input  1  serial bit returned from the chain tail.
REQ-013 Port: shift_en  output  1  chain flip-flops shift on the prog_clk edge where this is 1.
REQ-014 Port: busy  output  1  high in LOAD or CHECK.
REQ-015 Port: done  output  1  high in DONE.
REQ-016 Port: err  output  1  readback parity mismatch; valid while done=1.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD, CHECK and DONE.
REQ-018 Transitions: IDLE or DONE with start=1 -> LOAD; LOAD after CHAIN_LEN bits have been shifted -> CHECK; CHECK after CHAIN_LEN cycles -> DONE; any state with abort=1 -> IDLE (abort has priority over start).
REQ-019 A 1-word buffer and a bit counter SHALL be used; s_ready = (state==LOAD) & buffer empty & remaining chain bits > 0.
REQ-020 A word SHALL be accepted on the cycle where s_valid & s_ready; shifting of that word SHALL begin on the next cycle, one bit per cycle, MSB first.
REQ-021 In LOAD, shift_en SHALL be 1 exactly in the cycles where the buffer holds a bit, with ccff_head equal to that bit; otherwise shift_en=0 and ccff_head=0.
REQ-022 When CHAIN_LEN is not a multiple of WORD_W, only the top (CHAIN_LEN mod WORD_W) bits of the final word SHALL be shifted; the remaining bits SHALL be discarded, and no further word SHALL be accepted.
REQ-023 During LOAD, the block SHALL accumulate the XOR parity P_load of every bit shifted.
REQ-024 In CHECK, shift_en SHALL be 1 for exactly CHAIN_LEN cycles with ccff_head = ccff_tail (recirculation, leaving the chain contents unchanged), and the block SHALL accumulate the XOR parity P_rb of ccff_tail.
REQ-025 On entry to DONE, err SHALL be set to P_load ^ P_rb, and done=1; both SHALL hold until start, abort or reset.
REQ-026 A start received in DONE SHALL clear done, err, the parities and the counters, then enter LOAD.
REQ-027 start received in LOAD or CHECK SHALL be ignored.
REQ-028 Counters SHALL be clog2(CHAIN_LEN+1) bits wide and SHALL NOT wrap.
REQ-029 When s_valid=0 with the buffer empty, shift_en SHALL be 0 and no bit SHALL be lost or duplicated.

Reset
REQ-030 prog_reset=1 SHALL force IDLE and drive s_ready=0, ccff_head=0, shift_en=0, busy=0, done=0, err=0, and clear the buffer, counters and parities, in any state.
REQ-031 After a reset or abort during LOAD or CHECK, the chain contents SHALL be undefined; a new start is required.

Verification
REQ-032 Scenario 1: CHAIN_LEN=8, WORD_W=8, 8-bit shift-register chain model; start at t0, s_data=0xA5 with s_valid held. Required: accept at t1; ccff_head = 1,0,1,0,0,1,0,1 at t2..t9 with shift_en=1; CHECK at t10..t17; done=1 and err=0 at t18; the model holds 0xA5 with the first bit at the tail.
REQ-033 Scenario 2: same as scenario 1 but with ccff_tail stuck at 0 and s_data=0xA4 (odd parity). Required: done=1 and err=1.
REQ-034 Scenario 3: CHAIN_LEN=12, WORD_W=8, words 0xFF then 0xF0. Required: exactly 12 shift_en cycles in LOAD, the last 4 bits are 1, the low nibble is discarded, and s_ready=0 after the second accept.
REQ-035 Scenario 4: s_valid low for 5 cycles between words. Required: shift_en=0 during the gap and the bit sequence is identical to the gap-free run.
REQ-036 Scenario 5: abort after 3 bits of LOAD. Required: IDLE next cycle with all outputs 0; a following start and full load completes with err=0.
REQ-037 Scenario 6: prog_reset asserted in CHECK, and start asserted together with abort in DONE. Required: all outputs 0 on the next cycle in both cases, and the state is IDLE.
